// File: rtl/dma_fifo_pkg.sv
// Shared definitions for the multi-channel DMA FIFO with external memory.
// Optional error reporting is enabled by defining DMA_FIFO_MC_ERR_EN.
package dma_fifo_pkg;

  localparam int DWIDTH_DEF = 64;
  localparam int AWIDTH_DEF = 6;
  localparam int NUM_CH_DEF = 4;

  // Channel id width never drops below one bit, even for a single channel.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CHW_DEF = ch_width(NUM_CH_DEF);

  typedef logic [CHW_DEF-1:0] ch_id_t;

  // Read-return record: what the read side presents one cycle after a pull.
  typedef struct packed {
    logic                  valid;
    ch_id_t                ch;
    logic [DWIDTH_DEF-1:0] data;
  } rd_ret_t;

endpackage

// File: rtl/dma_fifo_ch_ctrl.sv
// Per-channel pointer and occupancy bookkeeping. The parent decides whether a
// push or pull is accepted; this block only advances its state on the strobes.
module dma_fifo_ch_ctrl
  import dma_fifo_pkg::*;
#(
  parameter int AWIDTH   = AWIDTH_DEF,
  parameter int AFULL_TH = 4
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              push_en,
  input  logic              pull_en,
  output logic [AWIDTH-1:0] w_ptr,
  output logic [AWIDTH-1:0] r_ptr,
  output logic [AWIDTH:0]   depth_left,
  output logic              full,
  output logic              empty,
  output logic              afull
);

  localparam logic [AWIDTH:0]   DEPTH_V  = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0]   AFULL_V  = (AWIDTH+1)'(AFULL_TH);
  localparam logic [AWIDTH-1:0] PTR_ONE  = AWIDTH'(1);
  localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH+1)'(1);

  logic [AWIDTH-1:0] w_ptr_r;
  logic [AWIDTH-1:0] r_ptr_r;
  logic [AWIDTH:0]   depth_left_r;

  // Pointers wrap naturally at DEPTH; free count moves only on unbalanced traffic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_ptr_r      <= {AWIDTH{1'b0}};
      r_ptr_r      <= {AWIDTH{1'b0}};
      depth_left_r <= DEPTH_V;
    end else begin
      if (push_en) begin
        w_ptr_r <= w_ptr_r + PTR_ONE;
      end else begin
        w_ptr_r <= w_ptr_r;
      end
      if (pull_en) begin
        r_ptr_r <= r_ptr_r + PTR_ONE;
      end else begin
        r_ptr_r <= r_ptr_r;
      end
      case ({push_en, pull_en})
        2'b10:   depth_left_r <= depth_left_r - CNT_ONE;
        2'b01:   depth_left_r <= depth_left_r + CNT_ONE;
        default: depth_left_r <= depth_left_r;
      endcase
    end
  end

  assign w_ptr      = w_ptr_r;
  assign r_ptr      = r_ptr_r;
  assign depth_left = depth_left_r;
  assign full       = (depth_left_r == {(AWIDTH+1){1'b0}});
  assign empty      = (depth_left_r == DEPTH_V);
  assign afull      = (depth_left_r <= AFULL_V);

endmodule

// File: rtl/dma_fifo_mc_exmem.sv
// Multi-channel FIFO whose storage lives in an external synchronous RAM
// (one-cycle read latency). Each channel owns a DEPTH-entry slice of the RAM
// addressed as {channel, pointer}. Define DMA_FIFO_MC_ERR_EN to add sticky
// per-channel overflow/underflow flags with an err_clr input.
module dma_fifo_mc_exmem
  import dma_fifo_pkg::*;
#(
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int AWIDTH   = AWIDTH_DEF,
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int AFULL_TH = 4,
  localparam int CHW     = ch_width(NUM_CH)
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [CHW-1:0]               push_ch,
  input  logic [DWIDTH-1:0]            data_in,
  input  logic                         pull,
  input  logic [CHW-1:0]               pull_ch,
  output logic [DWIDTH-1:0]            data_out,
  output logic                         rd_valid,
  output logic [CHW-1:0]               rd_ch,
  output logic [NUM_CH-1:0]            full,
  output logic [NUM_CH-1:0]            empty,
  output logic [NUM_CH-1:0]            afull,
  output logic [NUM_CH*(AWIDTH+1)-1:0] depth_left,
`ifdef DMA_FIFO_MC_ERR_EN
  input  logic                         err_clr,
  output logic [NUM_CH-1:0]            ovf_err,
  output logic [NUM_CH-1:0]            udf_err,
`endif
  output logic                         mem_write,
  output logic [CHW+AWIDTH-1:0]        mem_waddr,
  output logic [DWIDTH-1:0]            mem_wdata,
  output logic                         mem_read,
  output logic [CHW+AWIDTH-1:0]        mem_raddr,
  input  logic [DWIDTH-1:0]            mem_rdata
);

  logic [AWIDTH-1:0] w_ptr_s [NUM_CH];
  logic [AWIDTH-1:0] r_ptr_s [NUM_CH];
  logic [NUM_CH-1:0] full_s;
  logic [NUM_CH-1:0] empty_s;
  logic [NUM_CH-1:0] push_en_s;
  logic [NUM_CH-1:0] pull_en_s;

  logic              push_hit_s;
  logic              pull_hit_s;
  logic              push_full_s;
  logic              pull_empty_s;
  logic [AWIDTH-1:0] push_wptr_s;
  logic [AWIDTH-1:0] pull_rptr_s;
  logic              push_ok_s;
  logic              pull_ok_s;

  logic              rd_valid_r;
  logic [CHW-1:0]    rd_ch_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dma_fifo_ch_ctrl #(
      .AWIDTH   (AWIDTH),
      .AFULL_TH (AFULL_TH)
    ) u_ctrl (
      .clk        (clk),
      .rst        (rst),
      .push_en    (push_en_s[g]),
      .pull_en    (pull_en_s[g]),
      .w_ptr      (w_ptr_s[g]),
      .r_ptr      (r_ptr_s[g]),
      .depth_left (depth_left[g*(AWIDTH+1) +: (AWIDTH+1)]),
      .full       (full_s[g]),
      .empty      (empty_s[g]),
      .afull      (afull[g])
    );
  end

  assign full  = full_s;
  assign empty = empty_s;

  // Select the addressed channel's state; ids with no matching channel stay rejected.
  always_comb begin
    push_hit_s   = 1'b0;
    pull_hit_s   = 1'b0;
    push_full_s  = 1'b1;
    pull_empty_s = 1'b1;
    push_wptr_s  = {AWIDTH{1'b0}};
    pull_rptr_s  = {AWIDTH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_ch == CHW'(c)) begin
        push_hit_s  = 1'b1;
        push_full_s = full_s[c];
        push_wptr_s = w_ptr_s[c];
      end else begin
        push_hit_s  = push_hit_s;
      end
      if (pull_ch == CHW'(c)) begin
        pull_hit_s   = 1'b1;
        pull_empty_s = empty_s[c];
        pull_rptr_s  = r_ptr_s[c];
      end else begin
        pull_hit_s   = pull_hit_s;
      end
    end
  end

  assign push_ok_s = push & push_hit_s & ~push_full_s;
  assign pull_ok_s = pull & pull_hit_s & ~pull_empty_s;

  // Fan accepted requests out to the owning channel controller.
  always_comb begin
    push_en_s = {NUM_CH{1'b0}};
    pull_en_s = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_ok_s && (push_ch == CHW'(c))) begin
        push_en_s[c] = 1'b1;
      end else begin
        push_en_s[c] = 1'b0;
      end
      if (pull_ok_s && (pull_ch == CHW'(c))) begin
        pull_en_s[c] = 1'b1;
      end else begin
        pull_en_s[c] = 1'b0;
      end
    end
  end

  // Memory strobes are gated by reset so nothing reaches the RAM while held.
  assign mem_write = push_ok_s & rst;
  assign mem_waddr = {push_ch, push_wptr_s};
  assign mem_wdata = data_in;
  assign mem_read  = pull_ok_s & rst;
  assign mem_raddr = {pull_ch, pull_rptr_s};

  // Track the read issued last cycle so its RAM data can be tagged on return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_r <= 1'b0;
      rd_ch_r    <= {CHW{1'b0}};
    end else begin
      rd_valid_r <= pull_ok_s;
      if (pull_ok_s) begin
        rd_ch_r <= pull_ch;
      end else begin
        rd_ch_r <= rd_ch_r;
      end
    end
  end

  assign rd_valid = rd_valid_r;
  assign rd_ch    = rd_ch_r;
  assign data_out = rd_valid_r ? mem_rdata : {DWIDTH{1'b0}};

`ifdef DMA_FIFO_MC_ERR_EN
  logic [NUM_CH-1:0] ovf_set_s;
  logic [NUM_CH-1:0] udf_set_s;
  logic [NUM_CH-1:0] ovf_r;
  logic [NUM_CH-1:0] udf_r;

  // A push into a full channel or a pull from an empty one raises that channel's flag.
  always_comb begin
    ovf_set_s = {NUM_CH{1'b0}};
    udf_set_s = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      if (push && (push_ch == CHW'(c)) && full_s[c]) begin
        ovf_set_s[c] = 1'b1;
      end else begin
        ovf_set_s[c] = 1'b0;
      end
      if (pull && (pull_ch == CHW'(c)) && empty_s[c]) begin
        udf_set_s[c] = 1'b1;
      end else begin
        udf_set_s[c] = 1'b0;
      end
    end
  end

  // Sticky error flags; a clear in the same cycle as a new error wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= {NUM_CH{1'b0}};
      udf_r <= {NUM_CH{1'b0}};
    end else if (err_clr) begin
      ovf_r <= {NUM_CH{1'b0}};
      udf_r <= {NUM_CH{1'b0}};
    end else begin
      ovf_r <= ovf_r | ovf_set_s;
      udf_r <= udf_r | udf_set_s;
    end
  end

  assign ovf_err = ovf_r;
  assign udf_err = udf_r;
`endif

endmodule

// File: tb/tb_dma_fifo_mc_exmem.sv
// Scoreboard bench for dma_fifo_mc_exmem: per-channel reference queues drive
// expectations, a separate monitor checks every read return. Works with or
// without DMA_FIFO_MC_ERR_EN.
module tb_dma_fifo_mc_exmem;

  localparam int DW    = 64;
  localparam int AW    = 6;
  localparam int NCH   = 4;
  localparam int DEPTH = 64;
  localparam int ATH   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic [1:0]    push_ch;
  logic [DW-1:0] data_in;
  logic          pull;
  logic [1:0]    pull_ch;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic [1:0]    rd_ch;
  logic [3:0]    full, empty, afull;
  logic [27:0]   depth_left;
  logic          mem_write, mem_read;
  logic [7:0]    mem_waddr, mem_raddr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef DMA_FIFO_MC_ERR_EN
  logic          err_clr;
  logic [3:0]    ovf_err, udf_err;
`endif

  dma_fifo_mc_exmem dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_ch    (push_ch),
    .data_in    (data_in),
    .pull       (pull),
    .pull_ch    (pull_ch),
    .data_out   (data_out),
    .rd_valid   (rd_valid),
    .rd_ch      (rd_ch),
    .full       (full),
    .empty      (empty),
    .afull      (afull),
    .depth_left (depth_left),
`ifdef DMA_FIFO_MC_ERR_EN
    .err_clr    (err_clr),
    .ovf_err    (ovf_err),
    .udf_err    (udf_err),
`endif
    .mem_write  (mem_write),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_read   (mem_read),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // External synchronous RAM with one-cycle read latency.
  logic [DW-1:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_write) ram[mem_waddr] <= mem_wdata;
    if (mem_read)  mem_rdata <= ram[mem_raddr];
  end

  // Reference model: contents of each channel as a queue, plus totals pushed/pulled.
  logic [DW-1:0] mq [NCH][$];
  int            wcnt [NCH];
  int            rcnt [NCH];
  bit            ovf_m [NCH];
  bit            udf_m [NCH];
  typedef struct { int ch; logic [DW-1:0] data; } exp_t;
  exp_t          exp_q [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      wcnt[c] = 0;
      rcnt[c] = 0;
      ovf_m[c] = 1'b0;
      udf_m[c] = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic check_status();
    for (int c = 0; c < NCH; c++) begin
      int free;
      free = DEPTH - mq[c].size();
      chk($sformatf("depth_left[%0d]", c), 64'(depth_left[c*7 +: 7]), 64'(free));
      chk($sformatf("full[%0d]", c),  64'(full[c]),  64'(free == 0));
      chk($sformatf("empty[%0d]", c), 64'(empty[c]), 64'(free == DEPTH));
      chk($sformatf("afull[%0d]", c), 64'(afull[c]), 64'(free <= ATH));
`ifdef DMA_FIFO_MC_ERR_EN
      chk($sformatf("ovf_err[%0d]", c), 64'(ovf_err[c]), 64'(ovf_m[c]));
      chk($sformatf("udf_err[%0d]", c), 64'(udf_err[c]), 64'(udf_m[c]));
`endif
    end
  endtask

  // One clock of stimulus: check settled status, drive, check strobes, advance model.
  task automatic cycle(input bit p, input int pc, input logic [DW-1:0] d,
                       input bit q, input int qc, input bit ec);
    bit p_ok, q_ok;
    @(negedge clk);
    check_status();
    push = p; push_ch = 2'(pc); data_in = d;
    pull = q; pull_ch = 2'(qc);
`ifdef DMA_FIFO_MC_ERR_EN
    err_clr = ec;
`endif
    #1;
    p_ok = p && (mq[pc].size() < DEPTH);
    q_ok = q && (mq[qc].size() > 0);
    chk("mem_write", 64'(mem_write), 64'(p_ok));
    chk("mem_read",  64'(mem_read),  64'(q_ok));
    if (p_ok) begin
      chk("mem_waddr", 64'(mem_waddr), 64'(pc * DEPTH + (wcnt[pc] % DEPTH)));
      chk("mem_wdata", mem_wdata, d);
    end
    if (q_ok) begin
      chk("mem_raddr", 64'(mem_raddr), 64'(qc * DEPTH + (rcnt[qc] % DEPTH)));
    end
    if (ec) begin
      for (int c = 0; c < NCH; c++) begin
        ovf_m[c] = 1'b0;
        udf_m[c] = 1'b0;
      end
    end else begin
      if (p && !p_ok) ovf_m[pc] = 1'b1;
      if (q && !q_ok) udf_m[qc] = 1'b1;
    end
    if (q_ok) begin
      exp_t e;
      e.ch = qc;
      e.data = mq[qc].pop_front();
      exp_q.push_back(e);
      rcnt[qc]++;
    end
    if (p_ok) begin
      mq[pc].push_back(d);
      wcnt[pc]++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 64'd0, 1'b0, 0, 1'b0);
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: every expected return must appear on the very next cycle, in order.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("rd_valid_unexpected", 64'(rd_valid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rd_ch", 64'(rd_ch), 64'(e.ch));
        chk("data_out", data_out, e.data);
      end
    end else begin
      chk("data_out_idle", data_out, 64'd0);
      if (exp_q.size() != 0) begin
        chk("rd_valid_missing", 64'(rd_valid), 64'd1);
        exp_q.delete();
      end
    end
  end

  initial begin
    rst = 1'b0;
    push = 1'b0; push_ch = 2'd0; data_in = 64'd0;
    pull = 1'b0; pull_ch = 2'd0;
`ifdef DMA_FIFO_MC_ERR_EN
    err_clr = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    check_status();
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_rd_ch", 64'(rd_ch), 64'd0);
    rst = 1'b1;
    idle(2);

    // Fill ch2 to full, one extra push, then clear errors and drain.
    for (int i = 0; i < 65; i++) cycle(1'b1, 2, rnd64(), 1'b0, 0, 1'b0);
    idle(1);
    cycle(1'b0, 0, 64'd0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 64; i++) cycle(1'b0, 0, 64'd0, 1'b1, 2, 1'b0);
    idle(1);

    // Four known words through ch1.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1, 64'(10 + i), 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 64'd0, 1'b1, 1, 1'b0);
    idle(2);

    // Same-channel push+pull on ch0: with three held, then with ch0 empty.
    for (int i = 0; i < 3; i++) cycle(1'b1, 0, rnd64(), 1'b0, 0, 1'b0);
    cycle(1'b1, 0, rnd64(), 1'b1, 0, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 64'd0, 1'b1, 0, 1'b0);
    cycle(1'b1, 0, rnd64(), 1'b1, 0, 1'b0);
    idle(2);
    cycle(1'b0, 0, 64'd0, 1'b1, 0, 1'b1);
    idle(2);

    // Fill ch3, then 100 interleaved cycles, then drain: exercises wrap.
    for (int i = 0; i < 64; i++) cycle(1'b1, 3, rnd64(), 1'b0, 0, 1'b0);
    for (int i = 0; i < 100; i++)
      cycle(1'($urandom_range(0, 1)), 3, rnd64(), 1'($urandom_range(0, 1)), 3, 1'b0);
    for (int i = 0; i < 70; i++) cycle(1'b0, 0, 64'd0, 1'b1, 3, 1'b0);
    cycle(1'b0, 0, 64'd0, 1'b0, 0, 1'b1);

    // Random traffic across all channels.
    for (int i = 0; i < 1500; i++)
      cycle(1'($urandom_range(0, 99) < 55), $urandom_range(0, 3), rnd64(),
            1'($urandom_range(0, 99) < 45), $urandom_range(0, 3),
            1'($urandom_range(0, 31) == 0));
    idle(2);

    // Reset while a read is in flight: its data must never be returned.
    cycle(1'b1, 0, rnd64(), 1'b0, 0, 1'b0);
    cycle(1'b0, 0, 64'd0, 1'b1, 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    push = 1'b1; push_ch = 2'd1; pull = 1'b1; pull_ch = 2'd0;
    #1;
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_mem_read", 64'(mem_read), 64'd0);
    @(negedge clk);
    check_status();
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_ch", 64'(rd_ch), 64'd0);
    push = 1'b0; pull = 1'b0;
    #2;
    rst = 1'b1;
    idle(4);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_fifo_mc_exmem.md
DMA_FIFO_MC_EXMEM -- requirements
Module: dma_fifo_mc_exmem

Interface
REQ-001 SHALL have parameter DWIDTH, default 64, data word width in bits.
REQ-002 SHALL have parameter AWIDTH, default 6, log2 of per-channel depth (DEPTH = 2**AWIDTH).
REQ-003 SHALL have parameter NUM_CH, default 4, number of logical channels; CHW = max(1, clog2(NUM_CH)).
REQ-004 SHALL have parameter AFULL_TH, default 4, almost-full threshold in free entries.
REQ-005 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: push  in  1  write request; push_ch  in  CHW  target channel; data_in  in  DWIDTH  write data.
REQ-007 SHALL have ports: pull  in  1  read request; pull_ch  in  CHW  source channel.
REQ-008 SHALL have ports: data_out  out  DWIDTH  read data; rd_valid  out  1  data_out valid; rd_ch  out  CHW  channel of data_out.
REQ-009 SHALL have ports: full, empty, afull  out  NUM_CH each  per-channel status; depth_left  out  NUM_CH*(AWIDTH+1)  per-channel free count, channel 0 in LSBs.
REQ-010 SHALL have ports: mem_write  out  1; mem_waddr  out  CHW+AWIDTH; mem_wdata  out  DWIDTH; mem_read  out  1; mem_raddr  out  CHW+AWIDTH; mem_rdata  in  DWIDTH (external synchronous RAM, 1-cycle read latency).
REQ-011 SHALL have ports: err_clr  in  1  clears sticky errors; ovf_err, udf_err  out  NUM_CH each (present only with macro, REQ-027).

Function
REQ-012 SHALL keep per channel: w_ptr, r_ptr (AWIDTH bits, wrap modulo DEPTH), depth_left (AWIDTH+1 bits, range 0..DEPTH).
REQ-013 SHALL derive full[c] = (depth_left[c]==0), empty[c] = (depth_left[c]==DEPTH), afull[c] = (depth_left[c] <= AFULL_TH), all combinational from registered counts.
REQ-014 SHALL accept push when push=1 and full[push_ch]=0; accept pull when pull=1 and empty[pull_ch]=0; both judged on pre-edge state.
REQ-015 SHALL on accepted push drive mem_write=1, mem_waddr={push_ch,w_ptr[push_ch]}, mem_wdata=data_in combinationally same cycle; increment w_ptr at clock edge.
REQ-016 SHALL on accepted pull drive mem_read=1, mem_raddr={pull_ch,r_ptr[pull_ch]} same cycle; increment r_ptr at clock edge.
REQ-017 SHALL assert rd_valid one cycle after accepted pull, with rd_ch registered and data_out = mem_rdata; data_out SHALL be 0 when rd_valid=0.
REQ-018 SHALL for push and pull on different channels accept each independently.
REQ-019 SHALL for push and pull on same channel: neither full nor empty -> both accepted, depth_left unchanged; empty -> push only; full -> pull only.
REQ-020 SHALL ignore rejected requests: no pointer, count, or memory-strobe change.
REQ-021 SHALL accept out-of-range channel ids (>= NUM_CH) as rejected requests.
REQ-022 SHALL never drive mem_write or mem_read high without an accepted request.

Reset
REQ-023 SHALL on rst low immediately clear all pointers, set depth_left=DEPTH, empty=all 1, full=0, afull=0 (if AFULL_TH<DEPTH), rd_valid=0, rd_ch=0, error flags 0.
REQ-024 SHALL discard any in-flight read when reset asserts mid-operation; no rd_valid after release for pre-reset pulls.
REQ-025 SHALL force mem_write=0 and mem_read=0 while rst low.

Configuration
REQ-026 SHALL use macro DMA_FIFO_MC_ERR_EN.
REQ-027 SHALL with macro defined: set ovf_err[c] on rejected push to full channel c, set udf_err[c] on rejected pull from empty channel c; flags sticky until err_clr=1 (clear wins over same-cycle set).
REQ-028 SHALL without macro: omit ovf_err, udf_err, err_clr ports and logic; rejections silent.

Structure
REQ-029 SHALL place in package dma_fifo_pkg: default DWIDTH/AWIDTH/NUM_CH constants, typedef for channel id, and typedef for read-return record {valid, ch, data}.
REQ-030 SHALL implement per-channel pointers/count in sub-module dma_fifo_ch_ctrl, instantiated NUM_CH times by generate; top holds arbitration-free muxing and read-return register.

Verification
REQ-031 Reset then idle -> depth_left=64 all channels, empty=4'b1111, full=0, rd_valid=0.
REQ-032 Push 64 words to ch2, 65th push -> full[2]=1, afull[2] from 60th push, 65th no mem_write, ovf_err[2]=1 (macro on); err_clr -> 0.
REQ-033 Push 0xA..0xD to ch1, pull ch1 x4 -> rd_valid one cycle after each pull, data_out 0xA,0xB,0xC,0xD, rd_ch=1, empty[1]=1.
REQ-034 Same-cycle push ch0 and pull ch0 with ch0 holding 3 -> depth_left[0]=61 unchanged; with ch0 empty -> push only, no rd_valid, udf_err[0]=1.
REQ-035 Push 64 then pull/push 100 interleaved on ch3 -> pointers wrap, data order preserved, no lost words.
REQ-036 Assert rst one cycle after pull -> rd_valid stays 0, all status at reset values.
